// File: rtl/hist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hist_ctrl
// Purpose  : Sequences one 256-bin dual-port RAM (ram_p) to build a gray-level
//            histogram per frame: clear all bins, accumulate one count per
//            accepted pixel with a pipelined read-modify-write (same-bin
//            forwarding), stream the 256 counts out, then pulse done.
// Ports    : clk, rst (sync, active-high)
//            frame_start / frame_end  frame control pulses
//            pix_valid, pix_data, pix_ready  pixel stream (8-bit bin index)
//            busy, done, sat_flag     status
//            hist_valid, hist_bin, hist_count  readout stream (no backpressure)
//            ram_data, ram_wren, ram_wraddress, ram_rden, ram_rdaddress,
//            ram_q                    ram_p master interface (q 1 cycle after
//                                     rden, read-during-write returns OLD data)
// Revision : 1.0 - initial release
// ============================================================================
module hist_ctrl #(
    parameter int BITWIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    input  logic                frame_end,
    input  logic                pix_valid,
    input  logic [7:0]          pix_data,
    output logic                pix_ready,
    output logic                busy,
    output logic                done,
    output logic                sat_flag,
    output logic                hist_valid,
    output logic [7:0]          hist_bin,
    output logic [BITWIDTH-1:0] hist_count,
    output logic [BITWIDTH-1:0] ram_data,
    output logic                ram_wren,
    output logic [7:0]          ram_wraddress,
    output logic                ram_rden,
    output logic [7:0]          ram_rdaddress,
    input  logic [BITWIDTH-1:0] ram_q
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_CLEAR = 3'd1;
    localparam logic [2:0] c_ST_ACCUM = 3'd2;
    localparam logic [2:0] c_ST_FLUSH = 3'd3;
    localparam logic [2:0] c_ST_READ  = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

    localparam logic [BITWIDTH-1:0] c_ONE = BITWIDTH'(1);

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    // Shared cycle counter: CLEAR address 0..255, READ address 0..255 plus
    // one drain cycle (256) in which the bin-255 beat is presented.
    logic [8:0]          r_cnt;

    // Stage 1 of the accumulate pipeline (pixel read issued last cycle).
    logic                r_s1_valid;
    logic [7:0]          r_s1_bin;
    // Write issued by stage 1 in the previous cycle; the RAM returns old data
    // for a read that collided with it, so that value is forwarded instead.
    logic                r_lw_valid;
    logic [7:0]          r_lw_bin;
    logic [BITWIDTH-1:0] r_lw_data;

    logic                r_sat;
    logic                r_hist_valid;
    logic [7:0]          r_hist_bin;

    logic                w_accept;
    logic                w_fwd;
    logic [BITWIDTH-1:0] w_old;
    logic                w_is_max;
    logic [BITWIDTH-1:0] w_new;

    assign w_accept = pix_valid && (r_state == c_ST_ACCUM);
    assign w_fwd    = r_lw_valid && (r_lw_bin == r_s1_bin);
    assign w_old    = w_fwd ? r_lw_data : ram_q;
    assign w_is_max = &w_old;
    assign w_new    = w_is_max ? w_old : (w_old + c_ONE);

    // Next state and RAM-side outputs
    always_comb begin
        w_state_nxt   = r_state;
        ram_wren      = 1'b0;
        ram_wraddress = 8'd0;
        ram_data      = '0;
        ram_rden      = 1'b0;
        ram_rdaddress = 8'd0;

        case (r_state)
            c_ST_IDLE:  if (frame_start) w_state_nxt = c_ST_CLEAR;
            c_ST_CLEAR: if (r_cnt == 9'd255) w_state_nxt = c_ST_ACCUM;
            c_ST_ACCUM: if (frame_end) w_state_nxt = c_ST_FLUSH;
            c_ST_FLUSH: w_state_nxt = c_ST_READ;
            c_ST_READ:  if (r_cnt == 9'd256) w_state_nxt = c_ST_DONE;
            c_ST_DONE:  w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase

        // Stage 1 is never valid during CLEAR, so the two writers never collide.
        if (r_state == c_ST_CLEAR) begin
            ram_wren      = 1'b1;
            ram_wraddress = r_cnt[7:0];
        end else if (r_s1_valid) begin
            ram_wren      = 1'b1;
            ram_wraddress = r_s1_bin;
            ram_data      = w_new;
        end

        if (w_accept) begin
            ram_rden      = 1'b1;
            ram_rdaddress = pix_data;
        end else if ((r_state == c_ST_READ) && !r_cnt[8]) begin
            ram_rden      = 1'b1;
            ram_rdaddress = r_cnt[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= 9'd0;
            r_s1_valid   <= 1'b0;
            r_s1_bin     <= 8'd0;
            r_lw_valid   <= 1'b0;
            r_lw_bin     <= 8'd0;
            r_lw_data    <= '0;
            r_sat        <= 1'b0;
            r_hist_valid <= 1'b0;
            r_hist_bin   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state != w_state_nxt) begin
                r_cnt <= 9'd0;
            end else if ((r_state == c_ST_CLEAR) || (r_state == c_ST_READ)) begin
                r_cnt <= r_cnt + 9'd1;
            end

            r_s1_valid <= w_accept;
            r_s1_bin   <= pix_data;
            r_lw_valid <= r_s1_valid;
            r_lw_bin   <= r_s1_bin;
            r_lw_data  <= w_new;

            if ((r_state == c_ST_IDLE) && frame_start) begin
                r_sat <= 1'b0;
            end else if (r_s1_valid && w_is_max) begin
                r_sat <= 1'b1;
            end

            r_hist_valid <= (r_state == c_ST_READ) && !r_cnt[8];
            r_hist_bin   <= r_cnt[7:0];
        end
    end

    assign pix_ready  = (r_state == c_ST_ACCUM);
    assign busy       = (r_state != c_ST_IDLE);
    assign done       = (r_state == c_ST_DONE);
    assign sat_flag   = r_sat;
    assign hist_valid = r_hist_valid;
    assign hist_bin   = r_hist_bin;
    assign hist_count = r_hist_valid ? ram_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_hist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hist_ctrl
// Purpose  : Self-checking bench for hist_ctrl. Two instances (BITWIDTH 16
//            and 4) share the same stimulus, each with its own ram_p model;
//            expected histograms come from counting the pixels sent in each
//            frame and saturating at the instance's counter maximum.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hist_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_start = 1'b0;
    logic       frame_end = 1'b0;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_data = 8'd0;

    always #5 clk = ~clk;

    // Instance 0: BITWIDTH 16
    logic        pix_ready16, busy16, done16, sat16, hv16, wren16, rden16;
    logic [7:0]  hb16, wa16, ra16;
    logic [15:0] hc16, wd16, q16;
    // Instance 1: BITWIDTH 4
    logic        pix_ready4, busy4, done4, sat4, hv4, wren4, rden4;
    logic [7:0]  hb4, wa4, ra4;
    logic [3:0]  hc4, wd4, q4;

    hist_ctrl #(.BITWIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready16),
        .busy(busy16), .done(done16), .sat_flag(sat16), .hist_valid(hv16),
        .hist_bin(hb16), .hist_count(hc16), .ram_data(wd16), .ram_wren(wren16),
        .ram_wraddress(wa16), .ram_rden(rden16), .ram_rdaddress(ra16), .ram_q(q16)
    );

    hist_ctrl #(.BITWIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready4),
        .busy(busy4), .done(done4), .sat_flag(sat4), .hist_valid(hv4),
        .hist_bin(hb4), .hist_count(hc4), .ram_data(wd4), .ram_wren(wren4),
        .ram_wraddress(wa4), .ram_rden(rden4), .ram_rdaddress(ra4), .ram_q(q4)
    );

    // ram_p models: registered read, read-during-write returns old data
    logic [15:0] mem16 [256];
    logic [3:0]  mem4  [256];
    always @(posedge clk) begin
        if (wren16) mem16[wa16] <= wd16;
        if (rden16) q16 <= mem16[ra16];
        if (wren4)  mem4[wa4]   <= wd4;
        if (rden4)  q4  <= mem4[ra4];
    end

    // Per-instance views for uniform checking
    logic        pr [2], bz [2], dn [2], st [2], hv [2], wr [2], rd [2];
    logic [7:0]  hb [2], wa [2], ra [2];
    logic [15:0] hc [2], wd [2];
    assign pr[0] = pix_ready16; assign pr[1] = pix_ready4;
    assign bz[0] = busy16;      assign bz[1] = busy4;
    assign dn[0] = done16;      assign dn[1] = done4;
    assign st[0] = sat16;       assign st[1] = sat4;
    assign hv[0] = hv16;        assign hv[1] = hv4;
    assign wr[0] = wren16;      assign wr[1] = wren4;
    assign rd[0] = rden16;      assign rd[1] = rden4;
    assign hb[0] = hb16;        assign hb[1] = hb4;
    assign wa[0] = wa16;        assign wa[1] = wa4;
    assign ra[0] = ra16;        assign ra[1] = ra4;
    assign hc[0] = hc16;        assign hc[1] = {12'd0, hc4};
    assign wd[0] = wd16;        assign wd[1] = {12'd0, wd4};

    // Readout monitor
    int cyc = 0;
    bit mon_clr = 1'b1;
    int got [2][256];
    int beat_n [2];
    int done_n [2];
    int last_cyc [2];
    int done_cyc [2];
    bit order_ok [2];

    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int k = 0; k < 2; k++) begin
            if (mon_clr) begin
                beat_n[k] = 0; done_n[k] = 0; order_ok[k] = 1'b1;
                last_cyc[k] = -10; done_cyc[k] = -20;
                for (int b = 0; b < 256; b++) got[k][b] = -1;
            end else begin
                if (hv[k] === 1'b1) begin
                    if (int'(hb[k]) != beat_n[k]) order_ok[k] = 1'b0;
                    got[k][hb[k]] = int'(hc[k]);
                    beat_n[k] = beat_n[k] + 1;
                    if (hb[k] == 8'd255) last_cyc[k] = cyc;
                end
                if (dn[k] === 1'b1) begin
                    done_n[k] = done_n[k] + 1;
                    done_cyc[k] = cyc;
                end
            end
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    bit         q_v [$];
    logic [7:0] q_d [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add_pix(input bit v, input logic [7:0] d);
        q_v.push_back(v);
        q_d.push_back(d);
    endtask

    // One full frame with the pixels queued in q_v/q_d. noise drives value-3
    // pixels outside ACCUM; fs_accum pulses frame_start inside ACCUM;
    // abort_at >= 0 applies rst once that many beats have been read out.
    task automatic run_frame(input bit noise, input bit fs_accum, input int abort_at);
        int cnt [256];
        int bad;
        int t;
        int ev;
        int maxv;
        int fb_bin;
        int fb_got;
        bit esat;
        for (int b = 0; b < 256; b++) cnt[b] = 0;
        for (int j = 0; j < q_v.size(); j++) if (q_v[j]) cnt[q_d[j]]++;

        frame_start = 1'b1; mon_clr = 1'b1;
        step();
        frame_start = 1'b0; mon_clr = 1'b0;

        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (st[k] !== 1'b0) $display("FAIL sat_clear_on_start inst%0d: sat_flag=%0b expected 0", k, st[k]);
            if (st[k] !== 1'b0) n_fail++;
        end

        bad = 0;
        for (int i = 0; i < 256; i++) begin
            pix_valid = noise; pix_data = 8'd3;
            for (int k = 0; k < 2; k++)
                if (wr[k] !== 1'b1 || wa[k] !== 8'(i) || wd[k] !== 16'd0 || pr[k] !== 1'b0 || rd[k] !== 1'b0) bad++;
            step();
        end
        n_checks++;
        if (bad != 0) begin
            $display("FAIL clear_writes: %0d bad CLEAR cycles, expected 0", bad);
            n_fail++;
        end

        bad = 0;
        if (q_v.size() == 0) begin
            pix_valid = 1'b0; frame_end = 1'b1;
            for (int k = 0; k < 2; k++) if (pr[k] !== 1'b1) bad++;
            step();
        end
        for (int j = 0; j < q_v.size(); j++) begin
            pix_valid = q_v[j]; pix_data = q_d[j];
            frame_end = (j == q_v.size() - 1);
            frame_start = fs_accum && (j == 0);
            for (int k = 0; k < 2; k++) if (pr[k] !== 1'b1) bad++;
            step();
        end
        frame_end = 1'b0; frame_start = 1'b0;
        pix_valid = noise; pix_data = 8'd3;
        n_checks++;
        if (bad != 0) begin
            $display("FAIL accum_ready: pix_ready low in %0d ACCUM samples, expected 0", bad);
            n_fail++;
        end

        n_checks++;
        if (pr[0] !== 1'b0 || pr[1] !== 1'b0 || bz[0] !== 1'b1 || bz[1] !== 1'b1) begin
            $display("FAIL flush_ready: pix_ready=%0b/%0b busy=%0b/%0b expected 0/0 1/1", pr[0], pr[1], bz[0], bz[1]);
            n_fail++;
        end

        if (abort_at >= 0) begin
            t = 0;
            while (beat_n[0] < abort_at && t < 800) begin step(); t++; end
            rst = 1'b1;
            step();
            rst = 1'b0;
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (bz[k] !== 1'b0 || hv[k] !== 1'b0 || t >= 800) begin
                    $display("FAIL abort_reset inst%0d: busy=%0b hist_valid=%0b waited=%0d expected busy=0 hist_valid=0", k, bz[k], hv[k], t);
                    n_fail++;
                end
            end
            pix_valid = 1'b0;
            for (int i = 0; i < 300; i++) step();
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (done_n[k] != 0 || bz[k] !== 1'b0) begin
                    $display("FAIL abort_no_done inst%0d: done pulses=%0d busy=%0b expected 0 and 0", k, done_n[k], bz[k]);
                    n_fail++;
                end
            end
        end else begin
            t = 0;
            while (!(done_n[0] > 0 && done_n[1] > 0) && t < 800) begin step(); t++; end
            pix_valid = 1'b0;
            step(); step();
            n_checks++;
            if (t >= 800) begin
                $display("FAIL done_timeout: waited %0d cycles, required done within 800", t);
                n_fail++;
            end
            for (int k = 0; k < 2; k++) begin
                maxv = (k == 0) ? 65535 : 15;
                esat = 1'b0;
                bad = 0; fb_bin = -1; fb_got = 0;
                for (int b = 0; b < 256; b++) begin
                    ev = (cnt[b] > maxv) ? maxv : cnt[b];
                    if (cnt[b] > maxv) esat = 1'b1;
                    if (got[k][b] != ev) begin
                        bad++;
                        if (fb_bin < 0) begin fb_bin = b; fb_got = got[k][b]; end
                    end
                end
                n_checks++;
                if (bad != 0) begin
                    $display("FAIL hist_counts inst%0d: %0d bins wrong, first bin %0d got %0d expected %0d", k, bad, fb_bin, fb_got, (cnt[fb_bin] > maxv) ? maxv : cnt[fb_bin]);
                    n_fail++;
                end
                n_checks++;
                if (beat_n[k] != 256 || !order_ok[k]) begin
                    $display("FAIL beat_sequence inst%0d: %0d beats in_order=%0b expected 256 and 1", k, beat_n[k], order_ok[k]);
                    n_fail++;
                end
                n_checks++;
                if (done_n[k] != 1 || done_cyc[k] != last_cyc[k] + 1) begin
                    $display("FAIL done_timing inst%0d: %0d pulses at offset %0d expected 1 pulse at offset 1", k, done_n[k], done_cyc[k] - last_cyc[k]);
                    n_fail++;
                end
                n_checks++;
                if (st[k] !== esat || bz[k] !== 1'b0) begin
                    $display("FAIL sat_and_idle inst%0d: sat_flag=%0b busy=%0b expected %0b and 0", k, st[k], bz[k], esat);
                    n_fail++;
                end
            end
        end
        q_v.delete();
        q_d.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({pr[k], bz[k], dn[k], st[k], hv[k], wr[k], rd[k]} !== 7'd0 || hb[k] !== 8'd0 || hc[k] !== 16'd0 || wa[k] !== 8'd0 || wd[k] !== 16'd0 || ra[k] !== 8'd0) begin
                $display("FAIL reset_outputs inst%0d: flags=%b bin=%0d count=%0d wa=%0d wd=%0d ra=%0d expected all 0", k, {pr[k], bz[k], dn[k], st[k], hv[k], wr[k], rd[k]}, hb[k], hc[k], wa[k], wd[k], ra[k]);
                n_fail++;
            end
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_empty_frame();
        run_frame(1'b0, 1'b0, -1);
    endtask

    task automatic test_forwarding();
        for (int i = 0; i < 4; i++) add_pix(1'b1, 8'd5);
        run_frame(1'b0, 1'b0, -1);
    endtask

    task automatic test_gaps();
        add_pix(1'b1, 8'd7); add_pix(1'b1, 8'd9); add_pix(1'b0, 8'd7);
        add_pix(1'b1, 8'd7); add_pix(1'b1, 8'd9); add_pix(1'b0, 8'd9);
        add_pix(1'b1, 8'd7);
        run_frame(1'b0, 1'b0, -1);
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 17; i++) add_pix(1'b1, 8'd200);
        run_frame(1'b0, 1'b0, -1);
        // next frame_start must clear sat_flag (checked at start of frame)
        add_pix(1'b1, 8'd1);
        run_frame(1'b0, 1'b0, -1);
    endtask

    task automatic test_ignored();
        add_pix(1'b1, 8'd10); add_pix(1'b1, 8'd11); add_pix(1'b1, 8'd10);
        run_frame(1'b1, 1'b1, -1);
    endtask

    task automatic test_reset_mid_read();
        add_pix(1'b1, 8'd42); add_pix(1'b1, 8'd42);
        run_frame(1'b0, 1'b0, 100);
        add_pix(1'b1, 8'd0); add_pix(1'b1, 8'd255);
        run_frame(1'b0, 1'b0, -1);
    endtask

    task automatic test_random();
        int len;
        for (int f = 0; f < 4; f++) begin
            len = int'($urandom_range(10, 60));
            for (int j = 0; j < len; j++) begin
                case (f)
                    0:       add_pix($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)));
                    1:       add_pix($urandom_range(0, 3) != 0, 8'($urandom_range(0, 3)));
                    2:       add_pix($urandom_range(0, 7) != 0, 8'($urandom_range(250, 251)));
                    default: add_pix(1'b1, 8'($urandom_range(100, 107)));
                endcase
            end
            run_frame(1'b0, 1'b0, -1);
        end
    endtask

    initial begin
        test_reset();
        test_empty_frame();
        test_forwarding();
        test_gaps();
        test_saturation();
        test_ignored();
        test_reset_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
